// File: rtl/msx_slot_expander.sv
`default_nettype none
// ---------------------------------------------------------------------------
// msx_slot_expander : primary/secondary slot decode plus MSX2 RAM mapper regs
// Revision 1.0
// ---------------------------------------------------------------------------
module msx_slot_expander #(
  parameter logic [3:0] EXPANDED        = 4'b1000,
  parameter int         MAPPER_SEG_BITS = 3,
  parameter int         MAPPER_SLOT     = 3,
  parameter int         MAPPER_SUBSLOT  = 0,
  parameter bit         MAPPER_READBACK = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [15:0]                 addr,
  input  logic [7:0]                  d_from_cpu,
  input  logic                        mreq_n,
  input  logic                        iorq_n,
  input  logic                        rd_n,
  input  logic                        wr_n,
  input  logic                        m1_n,
  input  logic                        rfrsh_n,
  input  logic [7:0]                  primary,
  output logic [3:0]                  SLTSL_n,
  output logic [15:0]                 SUBSLT_n,
  output logic [MAPPER_SEG_BITS+13:0] mapper_addr,
  output logic                        mapper_cs_n,
  output logic [7:0]                  d_to_cpu,
  output logic                        d_oe
);

  localparam int         SB       = MAPPER_SEG_BITS;
  localparam logic [1:0] MAP_SLOT = 2'(MAPPER_SLOT);
  localparam logic [3:0] MAP_IDX  = 4'(MAPPER_SLOT * 4 + MAPPER_SUBSLOT);

  logic [1:0]    page, ps, sub;
  logic          mem, at_ffff, slot_exp, io_hit, wr_edge;
  logic [7:0]    io_rd;
  logic [7:0]    subreg_q [4];
  logic [7:0]    subreg_d [4];
  logic [SB-1:0] seg_q [4];
  logic [SB-1:0] seg_d [4];
  logic          wr_n_q, wr_n_d;
  logic          armed_q, armed_d;

  always_comb begin
    page     = addr[15:14];
    ps       = primary[{page, 1'b0} +: 2];
    mem      = ~mreq_n & rfrsh_n;
    at_ffff  = (addr == 16'hFFFF);
    slot_exp = EXPANDED[ps];
    sub      = subreg_q[ps][{page, 1'b0} +: 2];
    io_hit   = ~iorq_n & m1_n & (addr[7:2] == 6'b111111);
    // armed_q blocks a strobe already low when reset releases from counting as an edge
    wr_edge  = wr_n_q & armed_q & ~wr_n;
  end

  always_comb begin
    SLTSL_n  = 4'hF;
    SUBSLT_n = 16'hFFFF;
    if (mem) SLTSL_n[ps] = 1'b0;
    if (mem & slot_exp & ~at_ffff) SUBSLT_n[{ps, sub}] = 1'b0;
    mapper_cs_n = EXPANDED[MAP_SLOT] ? SUBSLT_n[MAP_IDX] : SLTSL_n[MAP_SLOT];
  end

  assign mapper_addr = {seg_q[page], addr[13:0]};

  always_comb begin
    d_to_cpu         = 8'hFF;
    d_oe             = 1'b0;
    io_rd            = 8'hFF;
    io_rd[SB-1:0]    = seg_q[addr[1:0]];
    if (mem & ~rd_n & at_ffff & slot_exp) begin
      d_to_cpu = ~subreg_q[ps];
      d_oe     = 1'b1;
    end else if (MAPPER_READBACK && io_hit && !rd_n) begin
      d_to_cpu = io_rd;
      d_oe     = 1'b1;
    end
  end

  always_comb begin
    wr_n_d   = wr_n;
    armed_d  = armed_q | wr_n;
    subreg_d = subreg_q;
    seg_d    = seg_q;
    if (wr_edge & mem & at_ffff & slot_exp) subreg_d[ps] = d_from_cpu;
    if (wr_edge & io_hit & rfrsh_n) seg_d[addr[1:0]] = d_from_cpu[SB-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_n_q  <= 1'b1;
      armed_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        subreg_q[i] <= 8'h00;
        seg_q[i]    <= SB'(3 - i);
      end
    end else begin
      wr_n_q   <= wr_n_d;
      armed_q  <= armed_d;
      subreg_q <= subreg_d;
      seg_q    <= seg_d;
    end
  end

endmodule
`default_nettype wire
